// File: rtl/seg7_reader.sv
// Recovers hex digits from a multiplexed 7-segment bus; accept lands STABLE+1 edges after a new pattern appears.
// No backpressure: a passive monitor that samples every cycle, and a pattern that changes before it is stable is simply dropped.
module seg7_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        leds,
  input  logic [NDIG-1:0]   digit,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   err,
  output logic              valid
);

  localparam logic [3:0] RUN_MAX = 4'(STABLE);
  localparam logic [3:0] RUN_PRE = 4'(STABLE - 1);

  logic [7:0]      s_q;
  logic [7:0]      s_p;
  logic [NDIG-1:0] d_q;
  logic [NDIG-1:0] d_p;
  logic [3:0]      run;
  logic [NDIG-1:0] seen;
  logic [NDIG-1:0] seen_nxt;
  logic            legal;
  logic            same;
  logic            accept;
  logic            hex_ok;
  logic [3:0]      hex_nib;

  assign legal  = $onehot(d_q);
  assign same   = (s_q == s_p) && (d_q == d_p);
  // Only the step into STABLE accepts, so a long hold is not re-accepted.
  assign accept = legal && same && (run == RUN_PRE);

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = 4'h0;
    case (s_q[6:0])
      7'h3F: hex_nib = 4'h0;
      7'h06: hex_nib = 4'h1;
      7'h5B: hex_nib = 4'h2;
      7'h4F: hex_nib = 4'h3;
      7'h66: hex_nib = 4'h4;
      7'h6D: hex_nib = 4'h5;
      7'h7D: hex_nib = 4'h6;
      7'h07: hex_nib = 4'h7;
      7'h7F: hex_nib = 4'h8;
      7'h67: hex_nib = 4'h9;
      7'h77: hex_nib = 4'hA;
      7'h7C: hex_nib = 4'hB;
      7'h39: hex_nib = 4'hC;
      7'h5E: hex_nib = 4'hD;
      7'h79: hex_nib = 4'hE;
      7'h71: hex_nib = 4'hF;
      default: hex_ok = 1'b0;
    endcase
  end

  always_comb begin
    seen_nxt = seen;
    if (accept) seen_nxt = seen | d_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '0;
      s_p   <= '0;
      d_q   <= '0;
      d_p   <= '0;
      run   <= '0;
      seen  <= '0;
      value <= '0;
      dp    <= '0;
      err   <= '0;
      valid <= 1'b0;
    end else begin
      s_q <= leds;
      d_q <= digit;
      s_p <= s_q;
      d_p <= d_q;

      if (!legal)
        run <= '0;
      else if (!same)
        run <= 4'd1;
      else if (run != RUN_MAX)
        run <= run + 4'd1;

      valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NDIG; i++) begin
          if (d_q[i]) begin
            dp[i] <= s_q[7];
            // An undecodable pattern keeps the old nibble and only flags it.
            if (hex_ok) begin
              value[4*i +: 4] <= hex_nib;
              err[i]          <= 1'b0;
            end else begin
              err[i] <= 1'b1;
            end
          end
        end
        if (&seen_nxt) begin
          valid <= 1'b1;
          seen  <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed table, corner sequences, and random traffic against a sliding-window model.
module tb_seg7_reader;

  localparam int NDIG   = 4;
  localparam int STABLE = 4;
  localparam int PW     = 8 + NDIG;

  logic              clk;
  logic              reset;
  logic [7:0]        leds;
  logic [NDIG-1:0]   digit;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   err;
  logic              valid;

  seg7_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .leds  (leds),
    .digit (digit),
    .value (value),
    .dp    (dp),
    .err   (err),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: a digit is taken when the last STABLE sampled pairs are one
  // identical legal pair and the sample just before them was something else.
  logic [6:0]        codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [PW-1:0]     hist[$];
  logic [4*NDIG-1:0] m_value = '0;
  logic [NDIG-1:0]   m_dp    = '0;
  logic [NDIG-1:0]   m_err   = '0;
  logic [NDIG-1:0]   m_seen  = '0;
  logic              m_valid = 1'b0;

  initial for (int i = 0; i <= STABLE; i++) hist.push_back('0);

  function automatic bit window_ok();
    if (hist.size() < STABLE + 1) return 0;
    if (!$onehot(hist[1][NDIG-1:0])) return 0;
    if (hist[0] == hist[1]) return 0;
    for (int k = 2; k <= STABLE; k++)
      if (hist[k] != hist[1]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    logic [PW-1:0] pr;
    int            n;
    m_valid = 1'b0;
    if (reset) begin
      m_value = '0;
      m_dp    = '0;
      m_err   = '0;
      m_seen  = '0;
      hist.push_back('0);
    end else begin
      if (window_ok()) begin
        pr = hist[1];
        n  = -1;
        for (int v = 0; v < 16; v++)
          if (codes[v] == pr[PW-2:NDIG]) n = v;
        for (int i = 0; i < NDIG; i++) begin
          if (pr[i]) begin
            m_dp[i]   = pr[PW-1];
            m_seen[i] = 1'b1;
            if (n >= 0) begin
              m_value[4*i +: 4] = 4'(n);
              m_err[i]          = 1'b0;
            end else begin
              m_err[i] = 1'b1;
            end
          end
        end
        if (&m_seen) begin
          m_valid = 1'b1;
          m_seen  = '0;
        end
      end
      hist.push_back({leds, digit});
    end
    while (hist.size() > STABLE + 1) void'(hist.pop_front());
  end

  always @(negedge clk) begin
    if (valid === 1'b1) vcnt++;
    if (chk_en) begin
      chk("model_value", 32'(value), 32'(m_value));
      chk("model_dp",    32'(dp),    32'(m_dp));
      chk("model_err",   32'(err),   32'(m_err));
      chk("model_valid", 32'(valid), 32'(m_valid));
    end
  end

  task automatic cyc(input logic [7:0] l, input logic [NDIG-1:0] d, input logic r);
    leds  = l;
    digit = d;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic show(input logic [7:0] l, input logic [NDIG-1:0] d, input int n);
    repeat (n) cyc(l, d, 1'b0);
  endtask

  typedef struct {
    logic [7:0]        leds;
    logic [NDIG-1:0]   digit;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   err;
    logic              valid;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int v0;
    logic [7:0]      rl;
    logic [NDIG-1:0] rd;

    tbl[0]  = '{8'h3F, 4'b0001, 16'h0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{8'h6D, 4'b0010, 16'h0050, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{8'h77, 4'b0100, 16'h0A50, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{8'h4F, 4'b1000, 16'h3A50, 4'b0000, 4'b0000, 1'b1};
    tbl[4]  = '{8'h7E, 4'b0100, 16'h3A50, 4'b0000, 4'b0100, 1'b0};
    tbl[5]  = '{8'hF9, 4'b0100, 16'h3E50, 4'b0100, 4'b0000, 1'b0};
    tbl[6]  = '{8'h00, 4'b0001, 16'h3E50, 4'b0100, 4'b0001, 1'b0};
    tbl[7]  = '{8'h86, 4'b0001, 16'h3E51, 4'b0101, 4'b0000, 1'b0};
    tbl[8]  = '{8'h7C, 4'b0010, 16'h3EB1, 4'b0101, 4'b0000, 1'b0};
    tbl[9]  = '{8'h71, 4'b1000, 16'hFEB1, 4'b0101, 4'b0000, 1'b1};
    tbl[10] = '{8'h5B, 4'b0010, 16'hFE21, 4'b0101, 4'b0000, 1'b0};
    tbl[11] = '{8'hE7, 4'b1000, 16'h9E21, 4'b1101, 4'b0000, 1'b0};
    tbl[12] = '{8'h39, 4'b0100, 16'h9C21, 4'b1001, 4'b0000, 1'b0};
    tbl[13] = '{8'h5E, 4'b0001, 16'h9C2D, 4'b1000, 4'b0000, 1'b1};

    reset = 1'b1;
    leds  = '0;
    digit = '0;

    // Reset with random inputs, then an idle stretch that must stay silent.
    cyc(8'($urandom), NDIG'($urandom), 1'b1);
    cyc(8'($urandom), NDIG'($urandom), 1'b1);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_dp",    32'(dp),    32'h0);
    chk("reset_err",   32'(err),   32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk_en = 1;
    v0 = vcnt;
    repeat (20) cyc(8'h00, '0, 1'b0);
    chk("reset_idle_pulses", 32'(vcnt - v0), 32'd0);

    for (int r = 0; r < 14; r++) begin
      show(tbl[r].leds, tbl[r].digit, STABLE);
      cyc(8'h00, '0, 1'b0);
      chk($sformatf("tbl%0d_value", r), 32'(value), 32'(tbl[r].value));
      chk($sformatf("tbl%0d_dp", r),    32'(dp),    32'(tbl[r].dp));
      chk($sformatf("tbl%0d_err", r),   32'(err),   32'(tbl[r].err));
      chk($sformatf("tbl%0d_valid", r), 32'(valid), 32'(tbl[r].valid));
      cyc(8'h00, '0, 1'b0);
      chk($sformatf("tbl%0d_pulse_end", r), 32'(valid), 32'h0);
    end

    v0 = vcnt;
    show(8'h06, 4'b0010, STABLE - 1);
    cyc(8'h00, '0, 1'b0);
    cyc(8'h00, '0, 1'b0);
    chk("short_hold_value", 32'(value), 32'h9C2D);

    show(8'h3F, 4'b0011, 2 * STABLE);
    show(8'h3F, 4'b0000, 2 * STABLE);
    cyc(8'h00, '0, 1'b0);
    chk("bad_enable_value", 32'(value), 32'h9C2D);
    chk("bad_enable_err",   32'(err),   32'h0);

    show(8'h66, 4'b1000, 2);
    show(8'h67, 4'b1000, 1);
    show(8'h66, 4'b1000, STABLE);
    chk("glitch_not_yet", 32'(value), 32'h9C2D);
    cyc(8'h00, '0, 1'b0);
    chk("glitch_accept", 32'(value), 32'h4C2D);
    cyc(8'h00, '0, 1'b0);
    chk("corner_no_pulse", 32'(vcnt - v0), 32'd0);

    // Partial frame wiped by reset: the lone fourth digit must not complete it.
    cyc(8'h00, '0, 1'b1);
    cyc(8'h00, '0, 1'b0);
    show(8'h3F, 4'b0001, STABLE); cyc(8'h00, '0, 1'b0);
    show(8'h06, 4'b0010, STABLE); cyc(8'h00, '0, 1'b0);
    show(8'h5B, 4'b0100, STABLE); cyc(8'h00, '0, 1'b0);
    chk("midrst_partial", 32'(value), 32'h0210);
    cyc(8'h00, '0, 1'b1);
    chk("midrst_cleared", 32'(value), 32'h0);
    v0 = vcnt;
    show(8'h4F, 4'b1000, STABLE); cyc(8'h00, '0, 1'b0);
    cyc(8'h00, '0, 1'b0);
    chk("midrst_value", 32'(value), 32'h3000);
    chk("midrst_no_pulse", 32'(vcnt - v0), 32'd0);
    v0 = vcnt;
    show(8'h3F, 4'b0001, STABLE); cyc(8'h00, '0, 1'b0);
    show(8'h06, 4'b0010, STABLE); cyc(8'h00, '0, 1'b0);
    show(8'h5B, 4'b0100, STABLE); cyc(8'h00, '0, 1'b0);
    show(8'h4F, 4'b1000, STABLE); cyc(8'h00, '0, 1'b0);
    cyc(8'h00, '0, 1'b0);
    chk("newframe_value", 32'(value), 32'h3210);
    chk("newframe_pulses", 32'(vcnt - v0), 32'd1);

    for (int s = 0; s < 500; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        cyc(8'($urandom), NDIG'($urandom), 1'b1);
      end else begin
        if ($urandom_range(0, 3) == 0)
          rl = 8'($urandom);
        else
          rl = {1'($urandom), codes[$urandom_range(0, 15)]};
        if ($urandom_range(0, 7) == 0)
          rd = NDIG'($urandom);
        else
          rd = NDIG'(1) << $urandom_range(0, NDIG - 1);
        show(rl, rd, $urandom_range(1, STABLE + 3));
      end
    end
    cyc(8'h00, '0, 1'b0);
    cyc(8'h00, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Seven-segment display reader: the inverse of the team's hex-to-segment decoder. It samples a multiplexed seven-segment bus (one segment byte in PGFEDCBA order plus one-hot digit enables), waits until each digit's pattern has been stable for a set number of cycles, and converts the pattern back to a 4-bit hex value. It reassembles a full multi-digit word with decimal-point and error flags, and pulses `valid` once every digit has been refreshed. It is used as a self-check monitor on the display path and to read back the displayed value into the control logic.

## Interface
- `NDIG`, default 4: number of multiplexed digits.
- `STABLE`, default 4: consecutive identical samples required before a digit is accepted (range 2..15).
- `clk` input 1: system clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `leds` input 8: segment byte, bit7 = P (decimal point), bits 6:0 = GFEDCBA, active high.
- `digit` input NDIG: digit enables, active high; legal only when exactly one bit is set.
- `value` output 4*NDIG: recovered hex nibbles; digit i maps to `value[4i+3:4i]`.
- `dp` output NDIG: decimal point of each digit as last accepted.
- `err` output NDIG: last accepted pattern for digit i was not a legal hex code.
- `valid` output 1: one-cycle pulse when a frame completes, i.e. every digit has been accepted since the last pulse or reset.

## Operation
- **Input stage:** `leds` and `digit` are registered once, giving the sample pair (S, D).
- **Run counter:** counts consecutive cycles with an identical (S, D) pair.
  - Any change in S or D reloads the counter to 1.
  - The counter saturates at STABLE.
- **Illegal enables:** if D is zero or has more than one bit set, the counter is forced to 0 and nothing is accepted.
- **Accept event:** occurs only on the cycle the counter steps from STABLE-1 to STABLE. A digit held longer is not re-accepted. A digit accepted again after another digit was shown is re-accepted.
- **On accept of digit i:** `dp[i]` = S[7] and `seen[i]` is set. S[6:0] is then decoded against this table:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 67=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - Match: the nibble is written to slot i and `err[i]` is cleared.
  - No match, including 0x00 (blank): `err[i]` is set and slot i keeps its previous value.
- **Frame completion:** when `seen` becomes all ones (including on the accept that sets the last bit), `valid` pulses and `seen` clears in the same cycle.
  - Digits may arrive in any order.
  - Repeat accepts of an already-seen digit update its slot but do not advance the frame.
- **Reset:** `value`=0, `dp`=0, `err`=0, `valid`=0. `seen`, the run counter and the input registers are also cleared. A reset mid-frame discards the partial frame.

## Timing
- Let edge k be the first edge that samples a new legal pair on `leds`/`digit`.
- If the pair is held at the inputs through edge k+STABLE-1, `value`, `dp` and `err` show the new data after edge k+STABLE. Latency is therefore STABLE+1 edges from input change to output.
- `valid` rises after the same edge as the final digit's update and is high for exactly one cycle.
- A change at any edge before k+STABLE-1 aborts the accept; the count restarts from the new pair.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- `reset` takes priority over an accept occurring in the same cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs → `value`=0, `dp`=0, `err`=0, `valid`=0; no `valid` pulse within 20 idle cycles after release.
- **Full frame:** with STABLE=4, drive digit 0..3 = 3F, 6D, 77, 4F (0001, 0010, 0100, 1000), each held 4 cycles → a single `valid` pulse and `value`=16'h3A50 after the last digit's accept edge; `err`=0.
- **Short hold:** hold digit 1 for 3 cycles, then move on → slot 1 unchanged, no accept, no `valid`.
- **Illegal pattern and decimal point:** digit 2 shows 7E, then digit 2 shows F9 → after the first, `err[2]`=1 and slot 2 is unchanged; after the second, nibble 2 = E, `dp[2]`=1, `err[2]`=0.
- **Illegal enables and glitch:** `digit`=0000 or 0011 for any duration, and a single-cycle pattern glitch mid-hold → no accept; the count restarts and the accept lands exactly STABLE samples after the glitch ends.
- **Mid-frame reset:** reset after 3 of 4 digits are accepted → the fourth digit alone produces no `valid`; a complete new frame is required.
